lcd1602_cgram_anim: RTL
=======================

LCD1602_CGRAM_ANIM -- requirements
Module: lcd1602_cgram_anim

Interface
REQ-001 Parameter NUM_CHARS, default 2: custom glyphs per frame, legal range 1..8.
REQ-002 Parameter NUM_FRAMES, default 4: animation frames, legal range 1..8.
REQ-003 Parameter TICK_DIV, default 800000: clk cycles per LCD transfer step, even, >=4.
REQ-004 Parameter FRAME_HOLD, default 30: idle steps between frames, >=1.
REQ-005 Parameter CURSOR_ADDR, default 8'h00: DDRAM address of the first shown glyph.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low.
REQ-008 start_i  in  1  level; high in IDLE begins init sequence.
REQ-009 pause_i  in  1  level; high freezes animation at the end of the current frame.
REQ-010 wr_en_i  in  1  glyph RAM write strobe, one byte per cycle.
REQ-011 wr_addr_i  in  clog2(NUM_FRAMES*NUM_CHARS*8)  glyph byte address: frame*NUM_CHARS*8 + char*8 + row.
REQ-012 wr_data_i  in  8  glyph row, bits[4:0] used.
REQ-013 rs  out  1  LCD register select (0 command, 1 data).
REQ-014 rw  out  1  LCD read/write; constant 0.
REQ-015 en  out  1  LCD enable strobe.
REQ-016 data  out  8  LCD data bus.
REQ-017 busy_o  out  1  high in every state except IDLE.
REQ-018 frame_o  out  3  index of the frame most recently shown.

Function
REQ-019 Step counter 0..TICK_DIV-1 free-runs outside IDLE; one transfer per step.
REQ-020 rs/data update only at step count 0; en=1 for counts 1..TICK_DIV/2, else 0; data stable whenever en=1.
REQ-021 States: IDLE, INIT, SET_CGRAM, LOAD, SET_DDRAM, SHOW, HOLD.
REQ-022 IDLE: en=0, no transfers; start_i=1 sampled -> INIT, step counter cleared.
REQ-023 INIT: commands 8'h38, 8'h0C, 8'h06, 8'h01 (rs=0), one per step, then SET_CGRAM.
REQ-024 SET_CGRAM: one command 8'h40 (rs=0), then LOAD.
REQ-025 LOAD: NUM_CHARS*8 data steps (rs=1), byte = {3'b000, glyph[frame][char][row][4:0]}, char-major, row 0 first.
REQ-026 SET_DDRAM: one command 8'h80 | CURSOR_ADDR (rs=0), then SHOW.
REQ-027 SHOW: NUM_CHARS data steps (rs=1), bytes 8'h00..NUM_CHARS-1; frame_o <= current frame on the last SHOW step.
REQ-028 HOLD: FRAME_HOLD steps with en=0; then frame index increments, wrapping NUM_FRAMES-1 -> 0, and next state is SET_CGRAM.
REQ-029 pause_i=1 at the end of HOLD: stay in HOLD, frame index unchanged; resume on the first step boundary after pause_i=0.
REQ-030 pause_i has no effect outside HOLD; a frame in progress always completes.
REQ-031 NUM_FRAMES=1: frame index stays 0; the frame is reloaded every cycle of the loop.
REQ-032 Glyph RAM writes are accepted in every state. Bytes of the frame being loaded take effect only if written before their LOAD step; simultaneous write and read of one address returns the old byte.
REQ-033 start_i is ignored outside IDLE; only reset returns the block to IDLE.

Reset
REQ-034 reset=0 at any clk edge, including mid-transfer with en high: state IDLE, en=0, rs=0, rw=0, data=8'h00, busy_o=0, frame_o=0, frame index 0, all counters 0 on the next edge.
REQ-035 Glyph RAM contents are not cleared by reset.

Verification (NUM_CHARS=2, NUM_FRAMES=2, TICK_DIV=4, FRAME_HOLD=2)
REQ-036 Init: start_i=1 one cycle -> en pulses carry 38,0C,06,01 (rs=0), then 40 (rs=0); en high for exactly 2 cycles per 4-cycle step.
REQ-037 Frame load: glyph bytes 0..31 = addr value -> 16 LOAD bytes 00..0F (rs=1), then 80 (rs=0), then 00,01 (rs=1); frame_o=0.
REQ-038 Wrap: run two frames -> second LOAD sends bytes 10..1F and frame_o=1; third LOAD sends 00..0F and frame_o=0.
REQ-039 Pause: pause_i=1 during SHOW -> SHOW completes, then no en pulses while pause_i=1; release -> next LOAD is the following frame.
REQ-040 Reset mid-LOAD with en=1 -> next edge en=0, data=00, busy_o=0; start_i again -> INIT restarts with 38 and old glyph data is still shown.
REQ-041 Write during HOLD to address 16 with value 1F -> next LOAD of frame 1 sends 1F as its first byte.

Source files
------------

// File: rtl/lcd1602_cgram_anim.sv
// rtl/lcd1602_cgram_anim.sv - HD44780/LCD1602 CGRAM glyph animator with glyph RAM
module lcd1602_cgram_anim #(
    parameter int         NUM_CHARS   = 2,
    parameter int         NUM_FRAMES  = 4,
    parameter int         TICK_DIV    = 800000,
    parameter int         FRAME_HOLD  = 30,
    parameter logic [7:0] CURSOR_ADDR = 8'h00,
    localparam int        DEPTH       = NUM_FRAMES * NUM_CHARS * 8,
    localparam int        AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          pause_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    output logic          rs,
    output logic          rw,
    output logic          en,
    output logic [7:0]    data,
    output logic          busy_o,
    output logic [2:0]    frame_o
);

    // Index counter must span the longest per-state sequence (INIT needs 4).
    localparam int LOAD_LEN = NUM_CHARS * 8;
    localparam int MAX_A    = (LOAD_LEN > FRAME_HOLD) ? LOAD_LEN : FRAME_HOLD;
    localparam int IDX_MAX  = (MAX_A > 4) ? MAX_A : 4;
    localparam int IDX_W    = $clog2(IDX_MAX);
    localparam int STEP_W   = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SET_CGRAM,
        S_LOAD,
        S_SET_DDRAM,
        S_SHOW,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [STEP_W-1:0]  r_step;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_nxt_idx;
    logic [2:0]         r_frame;
    logic [2:0]         w_nxt_frame;
    logic [2:0]         r_frame_o;
    logic [2:0]         w_nxt_frame_o;
    logic               r_rs;
    logic               w_nxt_rs;
    logic [7:0]         r_data;
    logic [7:0]         w_nxt_data;
    logic               r_xfer;
    logic               w_nxt_xfer;
    logic               w_tick;
    logic [AW-1:0]      w_rd_addr;
    logic [4:0]         w_rd_data;
    logic [4:0]         r_mem [0:DEPTH-1];
    logic               w_unused;

    // Only the five glyph pixel bits are stored.
    assign w_unused  = &{1'b0, wr_data_i[7:5]};

    assign w_tick    = (r_state != S_IDLE) && (r_step == '0);
    assign w_rd_addr = AW'(int'(r_frame) * LOAD_LEN + int'(r_idx));
    assign w_rd_data = r_mem[w_rd_addr];

    assign rs      = r_rs;
    assign rw      = 1'b0;
    assign data    = r_data;
    assign en      = r_xfer && (r_step != '0) && (r_step <= STEP_W'(TICK_DIV / 2));
    assign busy_o  = (r_state != S_IDLE);
    assign frame_o = r_frame_o;

    // Glyph RAM: written in any state, never cleared; a same-edge read sees the old byte.
    always_ff @(posedge clk) begin
        if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
            r_mem[wr_addr_i] <= wr_data_i[4:0];
        end
    end

    // Step counter free-runs outside IDLE; count 0 is the transfer boundary.
    always_ff @(posedge clk) begin
        if (!reset || (r_state == S_IDLE)) begin
            r_step <= '0;
        end else if (r_step == STEP_W'(TICK_DIV - 1)) begin
            r_step <= '0;
        end else begin
            r_step <= r_step + 1'b1;
        end
    end

    // State and transfer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_frame   <= '0;
            r_frame_o <= '0;
            r_rs      <= 1'b0;
            r_data    <= 8'h00;
            r_xfer    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_idx     <= w_nxt_idx;
            r_frame   <= w_nxt_frame;
            r_frame_o <= w_nxt_frame_o;
            r_rs      <= w_nxt_rs;
            r_data    <= w_nxt_data;
            r_xfer    <= w_nxt_xfer;
        end
    end

    // Next-state logic: each boundary issues the current state's transfer and advances.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_idx     = r_idx;
        w_nxt_frame   = r_frame;
        w_nxt_frame_o = r_frame_o;
        w_nxt_rs      = r_rs;
        w_nxt_data    = r_data;
        w_nxt_xfer    = r_xfer;
        if (r_state == S_IDLE) begin
            w_nxt_xfer = 1'b0;
            if (start_i) begin
                w_nxt_state = S_INIT;
                w_nxt_idx   = '0;
            end
        end else if (w_tick) begin
            w_nxt_xfer = 1'b1;
            w_nxt_idx  = r_idx + 1'b1;
            case (r_state)
                S_INIT: begin
                    w_nxt_rs = 1'b0;
                    case (r_idx[1:0])
                        2'd0:    w_nxt_data = 8'h38;
                        2'd1:    w_nxt_data = 8'h0C;
                        2'd2:    w_nxt_data = 8'h06;
                        default: w_nxt_data = 8'h01;
                    endcase
                    if (r_idx == IDX_W'(3)) begin
                        w_nxt_state = S_SET_CGRAM;
                        w_nxt_idx   = '0;
                    end
                end
                S_SET_CGRAM: begin
                    w_nxt_rs    = 1'b0;
                    w_nxt_data  = 8'h40;
                    w_nxt_state = S_LOAD;
                    w_nxt_idx   = '0;
                end
                S_LOAD: begin
                    w_nxt_rs   = 1'b1;
                    w_nxt_data = {3'b000, w_rd_data};
                    if (r_idx == IDX_W'(LOAD_LEN - 1)) begin
                        w_nxt_state = S_SET_DDRAM;
                        w_nxt_idx   = '0;
                    end
                end
                S_SET_DDRAM: begin
                    w_nxt_rs    = 1'b0;
                    w_nxt_data  = 8'h80 | CURSOR_ADDR;
                    w_nxt_state = S_SHOW;
                    w_nxt_idx   = '0;
                end
                S_SHOW: begin
                    w_nxt_rs   = 1'b1;
                    w_nxt_data = 8'(r_idx);
                    if (r_idx == IDX_W'(NUM_CHARS - 1)) begin
                        w_nxt_frame_o = r_frame;
                        w_nxt_state   = S_HOLD;
                        w_nxt_idx     = '0;
                    end
                end
                S_HOLD: begin
                    // Bus stays quiet; pause is only honoured on the final hold step.
                    w_nxt_xfer = 1'b0;
                    if (r_idx == IDX_W'(FRAME_HOLD - 1)) begin
                        w_nxt_idx = r_idx;
                        if (!pause_i) begin
                            w_nxt_idx   = '0;
                            w_nxt_state = S_SET_CGRAM;
                            if (r_frame == 3'(NUM_FRAMES - 1)) begin
                                w_nxt_frame = '0;
                            end else begin
                                w_nxt_frame = r_frame + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_xfer  = 1'b0;
                end
            endcase
        end
    end

endmodule
